// File: rtl/special_reg_pkg.sv
// Shared encodings for the special register bank: command opcodes, FSM states
// and the special register addresses produced by the IR decoder.
package special_reg_pkg;

  // Register-list addresses for the three special registers.
  localparam int totalAddressLength = 4;
  localparam logic [totalAddressLength-1:0] ADDR_RADR = 4'd13;
  localparam logic [totalAddressLength-1:0] ADDR_RLI  = 4'd14;
  localparam logic [totalAddressLength-1:0] ADDR_SP   = 4'd15;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_LOADL = 3'd1,
    OP_LOADH = 3'd2,
    OP_PUSH  = 3'd3,
    OP_POP   = 3'd4
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PUSH_WR,
    ST_POP_RD,
    ST_POP_WB
  } state_e;

endpackage

// File: rtl/special_reg_bank_stack_guard.sv
// Full/empty compare on the stack pointer; only built when STACK_GUARD_EN is defined.
module stack_guard #(
  parameter int                    DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] SP_RESET   = 16'hFFFF,
  parameter logic [DATA_WIDTH-1:0] SP_LIMIT   = 16'hFF00
) (
  input  logic [DATA_WIDTH-1:0] sp_i,
  output logic                  full_o,
  output logic                  empty_o
);

  assign full_o  = (sp_i == SP_LIMIT);
  assign empty_o = (sp_i == SP_RESET);

endmodule

// File: rtl/special_reg_bank.sv
// RADR/RLI/SP register bank with half-word loads and a push/pop stack port.
// Optional overflow/underflow guard is compiled in with STACK_GUARD_EN.
module special_reg_bank
  import special_reg_pkg::*;
#(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = totalAddressLength,
  parameter logic [DATA_WIDTH-1:0] SP_RESET   = 16'hFFFF,
  parameter logic [DATA_WIDTH-1:0] SP_LIMIT   = 16'hFF00
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [2:0]                cmd_op,
  input  logic [DATA_WIDTH/2-1:0]   imm,
  input  logic                      setRegAddress,
  input  logic [ADDR_WIDTH-1:0]     regAddress,
  output logic [DATA_WIDTH-1:0]     radr,
  output logic [DATA_WIDTH-1:0]     rli,
  output logic [DATA_WIDTH-1:0]     sp,
  output logic [DATA_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic                      mem_we,
  output logic                      mem_re,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic                      stack_ovf,
  output logic                      stack_unf
);

  localparam int HALF = DATA_WIDTH / 2;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] radr_q, radr_d, rli_q, rli_d, sp_q, sp_d;
  logic sel_radr, sel_rli, sel_sp, accept, is_load, hi_half;
  logic push_go, pop_go, sp_full, sp_empty;

  assign sel_radr = setRegAddress && (regAddress == ADDR_WIDTH'(ADDR_RADR));
  assign sel_rli  = setRegAddress && (regAddress == ADDR_WIDTH'(ADDR_RLI));
  assign sel_sp   = setRegAddress && (regAddress == ADDR_WIDTH'(ADDR_SP));
  assign accept   = cmd_valid && (state_q == ST_IDLE);
  assign is_load  = (cmd_op == OP_LOADL) || (cmd_op == OP_LOADH);
  assign hi_half  = (cmd_op == OP_LOADH);
  assign push_go  = accept && sel_sp && (cmd_op == OP_PUSH);
  assign pop_go   = accept && sel_sp && (cmd_op == OP_POP);

  function automatic logic [DATA_WIDTH-1:0] load_half(input logic [DATA_WIDTH-1:0] cur,
                                                       input logic hi,
                                                       input logic [HALF-1:0] v);
    load_half = hi ? {v, cur[HALF-1:0]} : {cur[DATA_WIDTH-1:HALF], v};
  endfunction

`ifdef STACK_GUARD_EN
  logic ovf_q, unf_q;

  stack_guard #(
    .DATA_WIDTH (DATA_WIDTH),
    .SP_RESET   (SP_RESET),
    .SP_LIMIT   (SP_LIMIT)
  ) u_stack_guard (
    .sp_i    (sp_q),
    .full_o  (sp_full),
    .empty_o (sp_empty)
  );

  // A refused push/pop sets its flag and leaves the FSM in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | (push_go && sp_full);
      unf_q <= unf_q | (pop_go && sp_empty);
    end
  end

  assign stack_ovf = ovf_q;
  assign stack_unf = unf_q;
`else
  assign sp_full   = 1'b0;
  assign sp_empty  = 1'b0;
  assign stack_ovf = 1'b0;
  assign stack_unf = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      radr_q <= '0;
      rli_q  <= '0;
      sp_q   <= SP_RESET;
    end else begin
      radr_q <= radr_d;
      rli_q  <= rli_d;
      sp_q   <= sp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    radr_d  = radr_q;
    rli_d   = rli_q;
    sp_d    = sp_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && is_load) begin
          if (sel_radr) radr_d = load_half(radr_q, hi_half, imm);
          if (sel_rli)  rli_d  = load_half(rli_q,  hi_half, imm);
          if (sel_sp)   sp_d   = load_half(sp_q,   hi_half, imm);
        end
        if (push_go && !sp_full)  state_d = ST_PUSH_WR;
        if (pop_go  && !sp_empty) state_d = ST_POP_RD;
      end
      ST_PUSH_WR: begin
        sp_d    = sp_q - DATA_WIDTH'(1);
        state_d = ST_IDLE;
      end
      ST_POP_RD: state_d = ST_POP_WB;
      ST_POP_WB: begin
        rli_d   = mem_rdata;
        sp_d    = sp_q + DATA_WIDTH'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes and address come from state alone so reset kills them instantly.
  always_comb begin
    cmd_ready = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    case (state_q)
      ST_IDLE:    cmd_ready = 1'b1;
      ST_PUSH_WR: begin
        mem_we   = 1'b1;
        mem_addr = sp_q - DATA_WIDTH'(1);
      end
      ST_POP_RD: begin
        mem_re   = 1'b1;
        mem_addr = sp_q;
      end
      default: ;
    endcase
  end

  assign radr      = radr_q;
  assign rli       = rli_q;
  assign sp        = sp_q;
  assign mem_wdata = rli_q;

endmodule

// File: tb/tb_special_reg_bank.sv
// Self-checking bench for special_reg_bank; memory strobes are matched against
// a queue of expected accesses. Guard-dependent expectations follow STACK_GUARD_EN.
module tb_special_reg_bank;
  import special_reg_pkg::*;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n, cmd_valid, cmd_ready, setRegAddress;
  logic [2:0]    cmd_op;
  logic [7:0]    imm;
  logic [totalAddressLength-1:0] regAddress;
  logic [DW-1:0] radr, rli, sp, mem_addr, mem_wdata, mem_rdata, rd_val;
  logic          mem_we, mem_re, stack_ovf, stack_unf;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b1;

  typedef struct packed {
    logic          we;
    logic [DW-1:0] addr;
    logic [DW-1:0] data;
  } acc_t;
  acc_t sb[$];

  always #5 clk = ~clk;

  special_reg_bank dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .imm(imm), .setRegAddress(setRegAddress), .regAddress(regAddress),
    .radr(radr), .rli(rli), .sp(sp), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );

  // Memory returns read data one cycle after mem_re.
  always @(posedge clk) mem_rdata <= mem_re ? rd_val : 16'hDEAD;

  always @(negedge clk) begin
    acc_t e;
    if (mon_en && rst_n && (mem_we || mem_re)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL mem_unexpected: got we=%0b re=%0b addr=%h, expected no access",
                 mem_we, mem_re, mem_addr);
      end else begin
        e = sb.pop_front();
        if (mem_we !== e.we || mem_re !== !e.we || mem_addr !== e.addr ||
            (e.we && mem_wdata !== e.data)) begin
          errors++;
          $display("FAIL mem_access: got we=%0b re=%0b addr=%h data=%h, expected we=%0b addr=%h data=%h",
                   mem_we, mem_re, mem_addr, mem_wdata, e.we, e.addr, e.data);
        end
      end
    end
  end

  task automatic cmd(input logic [2:0] op, input logic set,
                     input logic [totalAddressLength-1:0] a, input logic [7:0] v);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; setRegAddress = set; regAddress = a; imm = v;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_op = 3'd0; setRegAddress = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (sp !== 16'hFFFF || radr !== 16'h0 || rli !== 16'h0) begin
      errors++;
      $display("FAIL reset_regs: got sp=%h radr=%h rli=%h, expected ffff 0000 0000", sp, radr, rli);
    end
    checks++;
    if (cmd_ready !== 1'b1 || stack_ovf !== 1'b0 || stack_unf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got ready=%0b ovf=%0b unf=%0b, expected 1 0 0", cmd_ready, stack_ovf, stack_unf);
    end
    checks++;
    if (mem_we !== 1'b0 || mem_re !== 1'b0 || mem_addr !== 16'h0) begin
      errors++;
      $display("FAIL reset_mem: got we=%0b re=%0b addr=%h, expected 0 0 0000", mem_we, mem_re, mem_addr);
    end
  endtask

  task automatic test_load();
    cmd(OP_LOADL, 1'b1, ADDR_RADR, 8'h34);
    checks++;
    if (radr !== 16'h0034 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL loadl_radr: got radr=%h ready=%0b, expected 0034 1", radr, cmd_ready);
    end
    cmd(OP_LOADH, 1'b1, ADDR_RADR, 8'h12);
    @(negedge clk);
    checks++;
    if (radr !== 16'h1234 || rli !== 16'h0 || sp !== 16'hFFFF) begin
      errors++;
      $display("FAIL loadh_radr: got radr=%h rli=%h sp=%h, expected 1234 0000 ffff", radr, rli, sp);
    end
  endtask

  task automatic test_push();
    cmd(OP_LOADL, 1'b1, ADDR_RLI, 8'hEF);
    cmd(OP_LOADH, 1'b1, ADDR_RLI, 8'hBE);
    checks++;
    if (rli !== 16'hBEEF) begin
      errors++;
      $display("FAIL load_rli: got rli=%h, expected beef", rli);
    end
    sb.push_back('{we: 1'b1, addr: 16'hFFFE, data: 16'hBEEF});
    cmd(OP_PUSH, 1'b1, ADDR_SP, 8'h00);
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0 || sp !== 16'hFFFF) begin
      errors++;
      $display("FAIL push_busy: got ready=%0b sp=%h, expected 0 ffff", cmd_ready, sp);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || sp !== 16'hFFFE || sb.size() != 0) begin
      errors++;
      $display("FAIL push_done: got ready=%0b sp=%h pending=%0d, expected 1 fffe 0", cmd_ready, sp, sb.size());
    end
  endtask

  task automatic test_pop();
    rd_val = 16'hCAFE;
    sb.push_back('{we: 1'b0, addr: 16'hFFFE, data: 16'h0});
    cmd(OP_POP, 1'b1, ADDR_SP, 8'h00);
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL pop_rd_busy: got ready=%0b, expected 0", cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0 || rli !== 16'hBEEF || sp !== 16'hFFFE) begin
      errors++;
      $display("FAIL pop_wb_busy: got ready=%0b rli=%h sp=%h, expected 0 beef fffe", cmd_ready, rli, sp);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || rli !== 16'hCAFE || sp !== 16'hFFFF || sb.size() != 0) begin
      errors++;
      $display("FAIL pop_done: got ready=%0b rli=%h sp=%h pending=%0d, expected 1 cafe ffff 0",
               cmd_ready, rli, sp, sb.size());
    end
  endtask

  task automatic test_drop();
    cmd(OP_LOADL, 1'b0, ADDR_RADR, 8'h99);
    cmd(OP_LOADH, 1'b1, 4'd2, 8'h77);
    checks++;
    if (radr !== 16'h1234 || rli !== 16'hCAFE || sp !== 16'hFFFF) begin
      errors++;
      $display("FAIL drop_load: got radr=%h rli=%h sp=%h, expected 1234 cafe ffff", radr, rli, sp);
    end
    cmd(OP_PUSH, 1'b1, ADDR_RADR, 8'h00);
    checks++;
    if (cmd_ready !== 1'b1 || sp !== 16'hFFFF) begin
      errors++;
      $display("FAIL drop_push: got ready=%0b sp=%h, expected 1 ffff", cmd_ready, sp);
    end
    cmd(3'd7, 1'b1, ADDR_SP, 8'h12);
    checks++;
    if (cmd_ready !== 1'b1 || sp !== 16'hFFFF || radr !== 16'h1234) begin
      errors++;
      $display("FAIL drop_op7: got ready=%0b sp=%h radr=%h, expected 1 ffff 1234", cmd_ready, sp, radr);
    end
  endtask

  task automatic test_guard();
    logic          exp_ready, exp_ovf, exp_unf;
    logic [DW-1:0] exp_rli, exp_sp_pop, exp_sp_push;
`ifdef STACK_GUARD_EN
    exp_ready = 1'b1; exp_ovf = 1'b1; exp_unf = 1'b1;
    exp_rli = 16'hCAFE; exp_sp_pop = 16'hFFFF; exp_sp_push = 16'hFF00;
`else
    exp_ready = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0;
    exp_rli = 16'h1111; exp_sp_pop = 16'h0000; exp_sp_push = 16'hFEFF;
    sb.push_back('{we: 1'b0, addr: 16'hFFFF, data: 16'h0});
`endif
    rd_val = 16'h1111;
    cmd(OP_POP, 1'b1, ADDR_SP, 8'h00);
    @(negedge clk);
    checks++;
    if (cmd_ready !== exp_ready || stack_unf !== exp_unf) begin
      errors++;
      $display("FAIL pop_empty: got ready=%0b unf=%0b, expected %0b %0b", cmd_ready, stack_unf, exp_ready, exp_unf);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (sp !== exp_sp_pop || rli !== exp_rli) begin
      errors++;
      $display("FAIL pop_empty_regs: got sp=%h rli=%h, expected %h %h", sp, rli, exp_sp_pop, exp_rli);
    end
    cmd(OP_LOADL, 1'b1, ADDR_SP, 8'h00);
    cmd(OP_LOADH, 1'b1, ADDR_SP, 8'hFF);
    checks++;
    if (sp !== 16'hFF00) begin
      errors++;
      $display("FAIL load_sp: got sp=%h, expected ff00", sp);
    end
`ifndef STACK_GUARD_EN
    sb.push_back('{we: 1'b1, addr: 16'hFEFF, data: exp_rli});
`endif
    cmd(OP_PUSH, 1'b1, ADDR_SP, 8'h00);
    repeat (2) @(negedge clk);
    checks++;
    if (sp !== exp_sp_push || stack_ovf !== exp_ovf || cmd_ready !== 1'b1 || sb.size() != 0) begin
      errors++;
      $display("FAIL push_full: got sp=%h ovf=%0b ready=%0b pending=%0d, expected %h %0b 1 0",
               sp, stack_ovf, cmd_ready, sb.size(), exp_sp_push, exp_ovf);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] sp_now;
    sp_now = sp;
    mon_en = 1'b0;
    cmd(OP_POP, 1'b1, ADDR_SP, 8'h00);
    #3;
    checks++;
    if (mem_re !== 1'b1 || mem_addr !== sp_now) begin
      errors++;
      $display("FAIL mid_pop_rd: got re=%0b addr=%h, expected 1 %h", mem_re, mem_addr, sp_now);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_re !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 16'h0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_strobe: got re=%0b we=%0b addr=%h ready=%0b, expected 0 0 0000 1",
               mem_re, mem_we, mem_addr, cmd_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (sp !== 16'hFFFF || rli !== 16'h0 || radr !== 16'h0 || stack_ovf !== 1'b0 || stack_unf !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_regs: got sp=%h rli=%h radr=%h ovf=%0b unf=%0b, expected ffff 0000 0000 0 0",
               sp, rli, radr, stack_ovf, stack_unf);
    end
    mon_en = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; imm = 8'h0;
    setRegAddress = 1'b0; regAddress = '0; rd_val = 16'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_load();
    test_push();
    test_pop();
    test_drop();
    test_guard();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending accesses, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
